// File: rtl/fc_seq_ctrl_if.sv
// Bundle between fc_seq_ctrl and its neighbours: feature buffer, 3-lane MAC
// and the frame-level decision consumer.
interface fc_seq_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic                 feat_rd;
    logic [ADDR_W-1:0]    feat_addr;
    logic [5:0]           feat_data;
    logic                 mac_clr;
    logic                 mac_en;
    logic [5:0]           mac_lane;
    logic                 mac_done;
    logic signed [9:0]    acc0;
    logic signed [9:0]    acc1;
    // Decision handshake: a transfer happens on a rising edge where vad_valid
    // and vad_ready are both 1; once raised, vad_valid and its payload
    // (vad_flag, vad_score) hold unchanged until that transfer.
    logic                 vad_valid;
    logic                 vad_ready;
    logic                 vad_flag;
    logic signed [10:0]   vad_score;

    modport master (
        output feat_rd, feat_addr, mac_clr, mac_en, mac_lane,
               vad_valid, vad_flag, vad_score,
        input  feat_data, mac_done, acc0, acc1, vad_ready
    );

    modport slave (
        input  feat_rd, feat_addr, mac_clr, mac_en, mac_lane,
               vad_valid, vad_flag, vad_score,
        output feat_data, mac_done, acc0, acc1, vad_ready
    );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Frame sequencer for the binary FC output layer: clears the MAC, streams
// N_BEATS feature words into it, captures the class sums and hands out a decision.
module fc_seq_ctrl #(
    parameter int N_BEATS = 36,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_err_timeout,
    output logic          o_err_overrun,
    output logic [2:0]    o_state,
    fc_seq_ctrl_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_beat;
    logic [ADDR_W-1:0]   w_beat_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_mac_en;
    logic signed [9:0]   r_acc0;
    logic signed [9:0]   r_acc1;
    logic                r_err_timeout;
    logic                r_err_overrun;
    logic                w_feat_rd;
    logic                w_capture;
    logic                w_set_timeout;
    logic                w_accept;

    assign w_accept = (r_state == S_IDLE) && i_start;

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_wait_nxt    = r_wait;
        w_feat_rd     = 1'b0;
        w_capture     = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                w_beat_nxt  = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_feat_rd = 1'b1;
                if (r_beat == ADDR_W'(N_BEATS - 1)) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_beat_nxt = r_beat + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                // mac_done wins over the timeout on the last allowed cycle
                if (bus.mac_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUT;
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            S_OUT: begin
                if (bus.vad_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_wait        <= '0;
            r_mac_en      <= 1'b0;
            r_acc0        <= '0;
            r_acc1        <= '0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_beat   <= w_beat_nxt;
            r_wait   <= w_wait_nxt;
            r_mac_en <= w_feat_rd;
            if (w_capture) begin
                r_acc0 <= bus.acc0;
                r_acc1 <= bus.acc1;
            end
            if (w_accept) begin
                r_err_timeout <= 1'b0;
                r_err_overrun <= 1'b0;
            end else begin
                if (w_set_timeout) r_err_timeout <= 1'b1;
                if (i_start) r_err_overrun <= 1'b1;
            end
        end
    end

    // Buffer read data lands one cycle after the strobe, aligned with r_mac_en
    assign bus.feat_rd   = w_feat_rd;
    assign bus.feat_addr = w_feat_rd ? r_beat : '0;
    assign bus.mac_clr   = (r_state == S_CLR);
    assign bus.mac_en    = r_mac_en;
    assign bus.mac_lane  = r_mac_en ? bus.feat_data : 6'd0;
    assign bus.vad_valid = (r_state == S_OUT);
    assign bus.vad_score = {r_acc1[9], r_acc1} - {r_acc0[9], r_acc0};
    assign bus.vad_flag  = (r_acc1 > r_acc0);

    assign o_busy        = (r_state != S_IDLE);
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;
    assign o_state       = r_state;
endmodule
